// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state encodings, funct3 access sizes and alignment helper
package mem_arbiter_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IF_WAIT,
        ST_D_WAIT,
        ST_HALTED
    } state_t;

    // reserved funct3 codes count as misaligned so they never reach memory
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lane);
        return (size == SZ_B || size == SZ_BU) ? 1'b0 :
               (size == SZ_H || size == SZ_HU) ? lane[0] :
               (size == SZ_W) ? (lane != 2'b00) : 1'b1;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: store lane replication/strobes and load lane extraction with sign/zero extension
import mem_arbiter_pkg::*;

module mem_lane_fmt (
    input  logic [2:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [3:0]  st_strb,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [7:0]  b;
    logic [15:0] h;

    // strobes follow the byte offset; narrow data is replicated so any lane carries it
    always_comb begin
        st_strb  = st_size[1:0] == 2'b00 ? 4'b0001 << st_lane :
                   st_size[1:0] == 2'b01 ? 4'b0011 << st_lane : 4'b1111;
        st_wdata = st_size[1:0] == 2'b00 ? {4{st_data[7:0]}} :
                   st_size[1:0] == 2'b01 ? {2{st_data[15:0]}} : st_data;
        b        = ld_raw[{ld_lane, 3'b000} +: 8];
        h        = ld_lane[1] ? ld_raw[31:16] : ld_raw[15:0];
        ld_data  = ld_size == SZ_B  ? {{24{b[7]}}, b} :
                   ld_size == SZ_BU ? {24'b0, b} :
                   ld_size == SZ_H  ? {{16{h[15]}}, h} :
                   ld_size == SZ_HU ? {16'b0, h} : ld_raw;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between instruction fetch and load/store, data first
import mem_arbiter_pkg::*;

module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_err,
    input  logic        halt,
    output logic        stall,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      state, next;
    logic        we_q;
    logic [2:0]  size_q;
    logic [1:0]  lane_q;
    logic        d_bad;
    logic [3:0]  strb;
    logic [31:0] wfmt, ld_data;

    assign d_bad = misaligned(d_size, d_addr[1:0]);

    mem_lane_fmt u_fmt (
        .st_size  (d_size),
        .st_lane  (d_addr[1:0]),
        .st_data  (d_wdata),
        .st_strb  (strb),
        .st_wdata (wfmt),
        .ld_size  (size_q),
        .ld_lane  (lane_q),
        .ld_raw   (mem_rdata),
        .ld_data  (ld_data)
    );

    // state register; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next;
    end

    // capture the data access attributes on the issue cycle for the return cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= 1'b0;
            size_q <= SZ_W;
            lane_q <= 2'b00;
        end else if (state == ST_IDLE && !halt && d_req && !d_bad) begin
            we_q   <= d_we;
            size_q <= d_size;
            lane_q <= d_addr[1:0];
        end
    end

    // next state and all outputs; everything is held at zero while rst is asserted
    always_comb begin
        next      = state;
        mem_en    = 1'b0;
        mem_we    = 4'b0;
        mem_addr  = 32'b0;
        mem_wdata = 32'b0;
        if_rdata  = 32'b0;
        if_valid  = 1'b0;
        d_rdata   = 32'b0;
        d_valid   = 1'b0;
        d_err     = 1'b0;
        stall     = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (halt) begin
                        next = ST_HALTED;
                    end else if (d_req) begin
                        if (d_bad) begin
                            d_err = 1'b1;
                        end else begin
                            mem_en    = 1'b1;
                            mem_addr  = d_addr & 32'hFFFF_FFFC;
                            mem_we    = d_we ? strb : 4'b0;
                            mem_wdata = d_we ? wfmt : 32'b0;
                            next      = ST_D_WAIT;
                        end
                    end else if (if_req) begin
                        mem_en   = 1'b1;
                        mem_addr = if_addr & 32'hFFFF_FFFC;
                        next     = ST_IF_WAIT;
                    end
                end
                ST_IF_WAIT: begin
                    if_rdata = mem_rdata;
                    if_valid = 1'b1;
                    next     = ST_IDLE;
                end
                ST_D_WAIT: begin
                    d_rdata = we_q ? 32'b0 : ld_data;
                    d_valid = 1'b1;
                    next    = ST_IDLE;
                end
                default: ;
            endcase
            stall = (d_req && !d_valid) || (if_req && !if_valid) || state == ST_HALTED;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of fetch, contention, byte ops, misalignment, halt and reset
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, halt;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [2:0]  d_size;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, d_valid, d_err, stall, mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem [0:255];
    int          n_cmp = 0;
    int          n_bad = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_size    (d_size),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .d_err     (d_err),
        .halt      (halt),
        .stall     (stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // synchronous memory: read data one cycle after mem_en, byte-strobed writes
    always @(posedge clk) begin
        if (mem_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    initial begin
        mem[8'h04] <= 32'h0050_0093;
        mem[8'h05] <= 32'h1234_5678;
        mem[8'h10] <= 32'hDEAD_BEEF;
        mem[8'h40] <= 32'h1122_3344;
        mem_rdata  <= 32'h0;
        rst = 1'b1; halt = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 3'b010;
        d_addr = 32'h0; d_wdata = 32'h0; if_req = 1'b1; if_addr = 32'h10;
        mid;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_stall", stall, 0);
        chk("rst_valid", {if_valid, d_valid, d_err}, 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
        tick; rst = 1'b0; if_req = 1'b0;
        // fetch only
        tick; if_req = 1'b1; if_addr = 32'h10;
        mid;
        chk("f_mem_en", mem_en, 1);
        chk("f_addr", mem_addr, 32'h10);
        chk("f_stall", stall, 1);
        chk("f_valid_early", if_valid, 0);
        tick;
        mid;
        chk("f_valid", if_valid, 1);
        chk("f_rdata", if_rdata, 32'h0050_0093);
        chk("f_stall_rel", stall, 0);
        chk("f_no_en", mem_en, 0);
        // contention: data wins, then fetch
        tick; if_addr = 32'h14; d_req = 1'b1; d_we = 1'b0; d_size = 3'b010; d_addr = 32'h40;
        mid;
        chk("c_d_addr", mem_addr, 32'h40);
        chk("c_d_we", mem_we, 0);
        tick;
        mid;
        chk("c_d_valid", d_valid, 1);
        chk("c_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("c_no_overlap", mem_en, 0);
        chk("c_if_wait", if_valid, 0);
        tick; d_req = 1'b0;
        mid;
        chk("c_f_addr", mem_addr, 32'h14);
        tick;
        mid;
        chk("c_f_rdata", if_rdata, 32'h1234_5678);
        tick; if_req = 1'b0;
        // sb 0xAB at 0x103
        d_req = 1'b1; d_we = 1'b1; d_size = 3'b000; d_addr = 32'h103; d_wdata = 32'h1234_56AB;
        mid;
        chk("sb_we", mem_we, 4'b1000);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        chk("sb_addr", mem_addr, 32'h100);
        tick;
        mid;
        chk("sb_valid", d_valid, 1);
        chk("sb_rdata", d_rdata, 0);
        tick; d_we = 1'b0; d_wdata = 32'h0;
        mid;
        chk("lb_we", mem_we, 0);
        tick;
        mid;
        chk("lb_rdata", d_rdata, 32'hFFFF_FFAB);
        tick; d_size = 3'b100;
        tick;
        mid;
        chk("lbu_rdata", d_rdata, 32'h0000_00AB);
        tick; d_size = 3'b001; d_addr = 32'h102;
        tick;
        mid;
        chk("lh_rdata", d_rdata, 32'hFFFF_AB22);
        tick; d_size = 3'b101; d_addr = 32'h100;
        tick;
        mid;
        chk("lhu_rdata", d_rdata, 32'h0000_3344);
        tick; d_size = 3'b001; d_we = 1'b1; d_addr = 32'h102; d_wdata = 32'h0000_BEEF;
        mid;
        chk("sh_we", mem_we, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        tick;
        tick; d_req = 1'b0; d_we = 1'b0;
        // misaligned lh at 0x201
        tick; d_req = 1'b1; d_size = 3'b001; d_addr = 32'h201;
        mid;
        chk("mh_err", d_err, 1);
        chk("mh_no_en", mem_en, 0);
        chk("mh_valid", d_valid, 0);
        tick; d_req = 1'b0;
        mid;
        chk("mh_err_pulse", d_err, 0);
        chk("mh_stall_rel", stall, 0);
        // misaligned sw at 0x202
        tick; d_req = 1'b1; d_we = 1'b1; d_size = 3'b010; d_addr = 32'h202;
        mid;
        chk("mw_err", d_err, 1);
        chk("mw_no_access", {mem_en, mem_we}, 0);
        tick; d_req = 1'b0; d_we = 1'b0;
        mid;
        chk("mw_stall_rel", stall, 0);
        tick; d_req = 1'b1; d_size = 3'b011; d_addr = 32'h200;
        mid;
        chk("bad_size_err", d_err, 1);
        tick; d_req = 1'b0;
        // halt during IF_WAIT
        tick; if_req = 1'b1; if_addr = 32'h10;
        mid;
        chk("h_f_en", mem_en, 1);
        tick; halt = 1'b1;
        mid;
        chk("h_f_rdata", if_rdata, 32'h0050_0093);
        tick; if_addr = 32'h14;
        mid;
        chk("h_idle_no_en", mem_en, 0);
        chk("h_idle_stall", stall, 1);
        tick;
        mid;
        chk("h_halted_no_en", mem_en, 0);
        tick; halt = 1'b0; if_req = 1'b0;
        mid;
        chk("h_sticky_stall", stall, 1);
        chk("h_sticky_no_en", mem_en, 0);
        tick; rst = 1'b1;
        tick; rst = 1'b0;
        // reset during D_WAIT
        tick; d_req = 1'b1; d_size = 3'b010; d_addr = 32'h40;
        mid;
        chk("r_d_en", mem_en, 1);
        tick; rst = 1'b1;
        #1;
        chk("r_in_rst", {d_valid, stall, mem_en}, 0);
        #1; rst = 1'b0; d_req = 1'b0;
        mid;
        chk("r_no_valid", d_valid, 0);
        chk("r_idle_stall", stall, 0);
        tick;
        mid;
        chk("r_no_late_valid", d_valid, 0);
        tick; if_req = 1'b1; if_addr = 32'h10;
        mid;
        chk("r_fetch_en", mem_en, 1);
        tick;
        mid;
        chk("r_fetch_rdata", if_rdata, 32'h0050_0093);
        tick; if_req = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
